// File: rtl/main_mem_arbiter_pkg.sv
// Shared encodings and defaults for the main-memory arbiter and its picker.
package main_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_CPU) ? OWN_DBG : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker: a lone requester wins; a tie goes to the CPU
// under fixed priority, otherwise to whichever port did not own the last access.
module mem_arb_pick
  import main_mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant_owner
);

  always_comb begin
    grant_valid = cpu_req | dbg_req;
    grant_owner = OWN_CPU;
    if (cpu_req && dbg_req) begin
      grant_owner = (FIXED_PRIO != 0) ? OWN_CPU : other_owner(last_owner);
    end else if (dbg_req) begin
      grant_owner = OWN_DBG;
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Arbitrates the single-port main memory between the CPU and debug/loader ports,
// one outstanding transaction at a time, with every output registered.
//
//   state    | meaning
//   ST_IDLE  | sample requests, pick a winner, latch its access
//   ST_ISSUE | access presented to memory, winner's gnt high
//   ST_WAIT  | read latency countdown, capture douta on the last cycle
//   ST_RESP  | winner's rvalid high
module main_mem_arbiter
  import main_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t last_owner_q, last_owner_d;
  logic   we_q, we_d;
  logic [1:0] cnt_q, cnt_d;

  logic              cpu_gnt_d, dbg_gnt_d, cpu_rvalid_d, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_d, dbg_rdata_d;
  logic              mem_we_d, busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_din_d;

  logic   grant_valid;
  owner_t grant_owner;

  mem_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    dbg_rdata_d  = dbg_rdata;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_din_d    = mem_din;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d  = ST_ISSUE;
          owner_d  = grant_owner;
          if (grant_owner == OWN_CPU) begin
            we_d       = cpu_we;
            mem_addr_d = cpu_addr;
            mem_din_d  = cpu_wdata;
            cpu_gnt_d  = 1'b1;
          end else begin
            we_d       = dbg_we;
            mem_addr_d = dbg_addr;
            mem_din_d  = dbg_wdata;
            dbg_gnt_d  = 1'b1;
          end
          mem_we_d = we_d;
        end
      end
      ST_ISSUE: begin
        last_owner_d = owner_q;
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d  = mem_dout;
            cpu_rvalid_d = 1'b1;
          end else begin
            dbg_rdata_d  = mem_dout;
            dbg_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DBG;
      we_q         <= 1'b0;
      cnt_q        <= 2'd0;
      cpu_gnt      <= 1'b0;
      dbg_gnt      <= 1'b0;
      cpu_rvalid   <= 1'b0;
      dbg_rvalid   <= 1'b0;
      cpu_rdata    <= '0;
      dbg_rdata    <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      cpu_gnt      <= cpu_gnt_d;
      dbg_gnt      <= dbg_gnt_d;
      cpu_rvalid   <= cpu_rvalid_d;
      dbg_rvalid   <= dbg_rvalid_d;
      cpu_rdata    <= cpu_rdata_d;
      dbg_rdata    <= dbg_rdata_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_din      <= mem_din_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench: three arbiter instances (round-robin lat 1, fixed-priority lat 1,
// round-robin lat 3), each with its own behavioural memory.
module tb_main_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cpu_req [3], cpu_we [3], dbg_req [3], dbg_we [3];
  logic [7:0]  cpu_addr [3], dbg_addr [3];
  logic [15:0] cpu_wdata [3], dbg_wdata [3];
  logic        cpu_gnt [3], cpu_rvalid [3], dbg_gnt [3], dbg_rvalid [3];
  logic [15:0] cpu_rdata [3], dbg_rdata [3];
  logic        mem_we [3], busy [3];
  logic [7:0]  mem_addr [3];
  logic [15:0] mem_din [3], mem_dout [3];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    logic [15:0] mem [256];
    logic [15:0] pipe [3];

    main_mem_arbiter #(
      .ADDR_W(8), .DATA_W(16), .RD_LAT(LAT), .FIXED_PRIO((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_gnt(cpu_gnt[g]), .cpu_rvalid(cpu_rvalid[g]),
      .cpu_rdata(cpu_rdata[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_gnt(dbg_gnt[g]), .dbg_rvalid(dbg_rvalid[g]),
      .dbg_rdata(dbg_rdata[g]),
      .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_din(mem_din[g]),
      .mem_dout(mem_dout[g]), .busy(busy[g])
    );

    // Address registered on the edge, data out LAT edges later.
    always @(posedge clk) begin
      if (mem_we[g]) mem[mem_addr[g]] <= mem_din[g];
      pipe[0] <= mem[mem_addr[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_dout[g] = pipe[LAT-1];
  end

  function automatic logic gnt_of(input int k, input int p);
    return (p == 0) ? cpu_gnt[k] : dbg_gnt[k];
  endfunction

  function automatic logic rvalid_of(input int k, input int p);
    return (p == 0) ? cpu_rvalid[k] : dbg_rvalid[k];
  endfunction

  function automatic logic [15:0] rdata_of(input int k, input int p);
    return (p == 0) ? cpu_rdata[k] : dbg_rdata[k];
  endfunction

  task automatic drive(input int k, input int p, input logic req, input logic we,
                       input logic [7:0] a, input logic [15:0] d);
    if (p == 0) begin
      cpu_req[k] = req; cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d;
    end else begin
      dbg_req[k] = req; dbg_we[k] = we; dbg_addr[k] = a; dbg_wdata[k] = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(k, 0, 1'b0, 1'b0, 8'h00, 16'h0000);
      drive(k, 1, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single transaction starting in IDLE; cycle 0 is the cycle req is first seen.
  task automatic txn(input int k, input int p, input logic we, input logic [7:0] a,
                     input logic [15:0] d, output int gcyc, output int vcyc,
                     output logic [15:0] rd, output int we_cnt, output logic [7:0] gaddr);
    int cyc = 0;
    bit done = 1'b0;
    gcyc = -1; vcyc = -1; rd = '0; we_cnt = 0; gaddr = '0;
    drive(k, p, 1'b1, we, a, d);
    while (cyc < 30 && !done) begin
      @(negedge clk);
      cyc++;
      if (mem_we[k]) we_cnt++;
      if (gnt_of(k, p) && gcyc < 0) begin
        gcyc  = cyc;
        gaddr = mem_addr[k];
        drive(k, p, 1'b0, we, a, d);
      end
      if (rvalid_of(k, p)) begin
        vcyc = cyc;
        rd   = rdata_of(k, p);
      end
      done = (gcyc >= 0) && (we || vcyc >= 0);
    end
    drive(k, p, 1'b0, we, a, d);
    @(negedge clk);
    if (mem_we[k]) we_cnt++;
  endtask

  task automatic test_reset();
    logic [15:0] agg;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      agg = {10'd0, cpu_gnt[k], dbg_gnt[k], cpu_rvalid[k], dbg_rvalid[k], mem_we[k], busy[k]}
            | cpu_rdata[k] | dbg_rdata[k] | mem_din[k] | {8'd0, mem_addr[k]};
      total++;
      if (agg !== 16'h0000) begin
        bad++;
        $display("FAIL reset_outputs inst%0d: got %h want 0000", k, agg);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_wr_rd();
    int g, v, wc;
    logic [15:0] rd;
    logic [7:0] ga;
    do_reset();
    txn(0, 0, 1'b1, 8'h10, 16'hBEEF, g, v, rd, wc, ga);
    total++; if (g !== 1)     begin bad++; $display("FAIL wr_gnt_cycle: got %0d want 1", g); end
    total++; if (wc !== 1)    begin bad++; $display("FAIL wr_mem_we_cycles: got %0d want 1", wc); end
    total++; if (ga !== 8'h10) begin bad++; $display("FAIL wr_mem_addr: got %h want 10", ga); end
    txn(0, 0, 1'b0, 8'h10, 16'h0000, g, v, rd, wc, ga);
    total++; if (g !== 1)     begin bad++; $display("FAIL rd_gnt_cycle: got %0d want 1", g); end
    total++; if (v !== 3)     begin bad++; $display("FAIL rd_rvalid_cycle: got %0d want 3", v); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want beef", rd); end
    total++; if (wc !== 0)    begin bad++; $display("FAIL rd_mem_we_cycles: got %0d want 0", wc); end
  endtask

  // Both ports hold read requests; record the first n grants (owner, cycle).
  task automatic tie_run(input int k, input int n, output int own [4], output int cyc_at [4],
                         output int both);
    int cyc = 0;
    int got = 0;
    both = 0;
    for (int i = 0; i < 4; i++) begin own[i] = -1; cyc_at[i] = -1; end
    drive(k, 0, 1'b1, 1'b0, 8'h20, 16'h0);
    drive(k, 1, 1'b1, 1'b0, 8'h30, 16'h0);
    while (cyc < 40 && got < n) begin
      @(negedge clk);
      cyc++;
      if (cpu_gnt[k] && dbg_gnt[k]) both++;
      if (cpu_gnt[k] || dbg_gnt[k]) begin
        own[got]    = cpu_gnt[k] ? 0 : 1;
        cyc_at[got] = cyc;
        got++;
      end
    end
    drive(k, 0, 1'b0, 1'b0, 8'h20, 16'h0);
    drive(k, 1, 1'b0, 1'b0, 8'h30, 16'h0);
  endtask

  task automatic test_tie_round_robin();
    int own [4], at [4], both;
    int exp_own [4] = '{0, 1, 0, 1};
    int exp_at  [4] = '{1, 5, 9, 13};
    do_reset();
    tie_run(0, 4, own, at, both);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (own[i] !== exp_own[i]) begin
        bad++; $display("FAIL rr_owner[%0d]: got %0d want %0d", i, own[i], exp_own[i]);
      end
      total++;
      if (at[i] !== exp_at[i]) begin
        bad++; $display("FAIL rr_gnt_cycle[%0d]: got %0d want %0d", i, at[i], exp_at[i]);
      end
    end
    total++; if (both !== 0) begin bad++; $display("FAIL rr_double_gnt: got %0d want 0", both); end
  endtask

  task automatic test_fixed_prio();
    int own [4], at [4], both;
    do_reset();
    tie_run(1, 3, own, at, both);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (own[i] !== 0) begin
        bad++; $display("FAIL fp_owner[%0d]: got %0d want 0", i, own[i]);
      end
    end
    total++;
    if (at[2] !== 9) begin bad++; $display("FAIL fp_third_gnt_cycle: got %0d want 9", at[2]); end
  endtask

  task automatic test_coherence();
    int g, v, wc;
    logic [15:0] rd;
    logic [7:0] ga;
    do_reset();
    txn(0, 1, 1'b1, 8'h00, 16'h1234, g, v, rd, wc, ga);
    total++; if (g !== 1) begin bad++; $display("FAIL coh_dbg_gnt_cycle: got %0d want 1", g); end
    txn(0, 0, 1'b0, 8'h00, 16'h0000, g, v, rd, wc, ga);
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL coh_cpu_rdata: got %h want 1234", rd); end
    total++; if (v !== 3) begin bad++; $display("FAIL coh_rvalid_cycle: got %0d want 3", v); end
    total++;
    if (dbg_rdata[0] !== 16'h0000) begin
      bad++; $display("FAIL coh_dbg_rdata: got %h want 0000", dbg_rdata[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    int own [4], at [4], both;
    int rv = 0;
    do_reset();
    drive(0, 0, 1'b1, 1'b0, 8'h40, 16'h0);
    @(negedge clk);
    total++; if (cpu_gnt[0] !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", cpu_gnt[0]); end
    drive(0, 0, 1'b0, 1'b0, 8'h40, 16'h0);
    @(negedge clk);
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL mid_busy_wait: got %b want 1", busy[0]); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy[0], mem_we[0], cpu_rvalid[0]} !== 3'b000) begin
      bad++; $display("FAIL mid_reset_immediate: got %b want 000", {busy[0], mem_we[0], cpu_rvalid[0]});
    end
    repeat (3) begin
      @(negedge clk);
      if (cpu_rvalid[0] || dbg_rvalid[0]) rv++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (cpu_rvalid[0] || dbg_rvalid[0]) rv++;
    end
    total++; if (rv !== 0) begin bad++; $display("FAIL mid_no_rvalid: got %0d want 0", rv); end
    tie_run(0, 1, own, at, both);
    total++; if (own[0] !== 0) begin bad++; $display("FAIL mid_first_tie: got %0d want 0", own[0]); end
  endtask

  task automatic test_lat3();
    int g, v, wc, cyc, ng, g1, g2, vc;
    logic [15:0] rd;
    logic [7:0] ga;
    do_reset();
    txn(2, 1, 1'b1, 8'hFE, 16'h00FF, g, v, rd, wc, ga);
    total++; if (wc !== 1) begin bad++; $display("FAIL l3_preload_we: got %0d want 1", wc); end
    cyc = 0; ng = 0; g1 = -1; g2 = -1; vc = -1; rd = '0;
    drive(2, 0, 1'b1, 1'b0, 8'hFE, 16'h0);
    while (cyc < 30 && ng < 2) begin
      @(negedge clk);
      cyc++;
      if (cpu_gnt[2]) begin
        if (ng == 0) g1 = cyc; else g2 = cyc;
        ng++;
      end
      if (cpu_rvalid[2] && vc < 0) begin vc = cyc; rd = cpu_rdata[2]; end
    end
    drive(2, 0, 1'b0, 1'b0, 8'hFE, 16'h0);
    total++; if (g1 !== 1) begin bad++; $display("FAIL l3_gnt_cycle: got %0d want 1", g1); end
    total++; if (vc !== 5) begin bad++; $display("FAIL l3_rvalid_cycle: got %0d want 5", vc); end
    total++; if (rd !== 16'h00FF) begin bad++; $display("FAIL l3_rdata: got %h want 00ff", rd); end
    total++; if (g2 !== 7) begin bad++; $display("FAIL l3_next_gnt_cycle: got %0d want 7", g2); end
    total++;
    if (dbg_rdata[2] !== 16'h0000) begin
      bad++; $display("FAIL l3_dbg_rdata: got %h want 0000", dbg_rdata[2]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(k, 0, 1'b0, 1'b0, 8'h00, 16'h0000);
      drive(k, 1, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    test_reset();
    test_cpu_wr_rd();
    test_tie_round_robin();
    test_fixed_prio();
    test_coherence();
    test_reset_mid_read();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
